// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes.
// Retires one Booth digit per clock into a shift-add accumulator. In
// unsigned mode the operands are zero-extended, so the same signed
// datapath serves both modes. The product is held until it is accepted.
`timescale 1ns/1ps
module booth_r4_seq_mult #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   op1,
  input  logic [N-1:0]   op2,
  input  logic           tc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] P,
  output logic           busy
);

  // Number of Booth digits, which is also the number of RUN cycles.
  localparam int K  = (N + 2) / 2;
  localparam int AW = 2 * N + 4;
  localparam int CW = $clog2(K);
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  if ((N % 2) != 0 || N < 4) begin : g_bad_n
    $error("booth_r4_seq_mult: N must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic signed [AW-1:0]  acc;
  // Multiplicand, pre-shifted by two bits per digit so it is already aligned.
  logic signed [AW-1:0]  msh;
  // Multiplier, shifted right two bits per digit; bits [1:0] are the current pair.
  logic [N+1:0]          qsh;
  // Implicit q(2i-1) bit of the current Booth triplet.
  logic                  qprev;

  logic [N+1:0]          op1_x;
  logic [N+1:0]          op2_x;
  logic signed [AW-1:0]  acc_nxt;

  // Booth recoding of one triplet into a full-width two's complement partial
  // product; negation at full width keeps the most negative operand exact.
  function automatic logic signed [AW-1:0] booth_pp(input logic [2:0] trip,
                                                    input logic signed [AW-1:0] mm);
    case (trip)
      3'b001, 3'b010: return mm;
      3'b011:         return mm <<< 1;
      3'b100:         return -(mm <<< 1);
      3'b101, 3'b110: return -mm;
      default:        return '0;
    endcase
  endfunction

  // Operand extension to N+2 bits and next accumulator value.
  always_comb begin
    op1_x   = tc ? {{2{op1[N-1]}}, op1} : {2'b00, op1};
    op2_x   = tc ? {{2{op2[N-1]}}, op2} : {2'b00, op2};
    acc_nxt = acc + booth_pp({qsh[1:0], qprev}, msh);
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Control FSM and shift-add datapath; the product is registered on the last digit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      msh       <= '0;
      qsh       <= '0;
      qprev     <= 1'b0;
      out_valid <= 1'b0;
      P         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state <= RUN;
            msh   <= {{(N+2){op1_x[N+1]}}, op1_x};
            qsh   <= op2_x;
            qprev <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          msh   <= msh <<< 2;
          qsh   <= {{2{qsh[N+1]}}, qsh[N+1:2]};
          qprev <= qsh[1];
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            P         <= acc_nxt[2*N-1:0];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult: directed N=32 vector table,
// backpressure and reset-abort sequences, plus N=4 exhaustive and N=16
// random sweeps against a reference product.
`timescale 1ns/1ps
module tb_booth_r4_seq_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=32 instance
  logic        in_valid, in_ready, tc, out_valid, out_ready, busy;
  logic [31:0] op1, op2;
  logic [63:0] P;

  booth_r4_seq_mult #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .tc(tc), .out_valid(out_valid),
    .out_ready(out_ready), .P(P), .busy(busy)
  );

  // N=4 instance
  logic       s4_in_valid, s4_in_ready, s4_tc, s4_out_valid, s4_busy;
  logic [3:0] s4_op1, s4_op2;
  logic [7:0] s4_P;

  booth_r4_seq_mult #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(s4_in_valid), .in_ready(s4_in_ready),
    .op1(s4_op1), .op2(s4_op2), .tc(s4_tc), .out_valid(s4_out_valid),
    .out_ready(1'b1), .P(s4_P), .busy(s4_busy)
  );

  // N=16 instance
  logic        s16_in_valid, s16_in_ready, s16_tc, s16_out_valid, s16_busy;
  logic [15:0] s16_op1, s16_op2;
  logic [31:0] s16_P;

  booth_r4_seq_mult #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(s16_in_valid), .in_ready(s16_in_ready),
    .op1(s16_op1), .op2(s16_op2), .tc(s16_tc), .out_valid(s16_out_valid),
    .out_ready(1'b1), .P(s16_P), .busy(s16_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        t;
    logic [63:0] p;
    string       nm;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One N=32 operation with out_ready=1; operands are scrambled during RUN.
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic t,
                      input logic [63:0] exp, input string nm);
    int lat;
    @(negedge clk);
    op1 = a; op2 = b; tc = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = $urandom; op2 = $urandom; tc = ~t;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd17);
    chk({nm, " P"}, P, exp);
    @(posedge clk); #1;
    chk({nm, " idle in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, " idle out_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic t);
    int lat;
    logic [7:0] ea, eb, ex;
    ea = t ? {{4{a[3]}}, a} : {4'b0, a};
    eb = t ? {{4{b[3]}}, b} : {4'b0, b};
    ex = ea * eb;
    @(negedge clk);
    s4_op1 = a; s4_op2 = b; s4_tc = t; s4_in_valid = 1'b1;
    @(posedge clk); #1;
    s4_in_valid = 1'b0;
    lat = 0;
    while (!s4_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n4 latency", 64'(lat), 64'd3);
    chk("n4 P", 64'(s4_P), 64'(ex));
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic t);
    int lat;
    logic [31:0] ea, eb, ex;
    ea = t ? {{16{a[15]}}, a} : {16'b0, a};
    eb = t ? {{16{b[15]}}, b} : {16'b0, b};
    ex = ea * eb;
    @(negedge clk);
    s16_op1 = a; s16_op2 = b; s16_tc = t; s16_in_valid = 1'b1;
    @(posedge clk); #1;
    s16_in_valid = 1'b0;
    lat = 0;
    while (!s16_out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n16 latency", 64'(lat), 64'd9);
    chk("n16 P", 64'(s16_P), 64'(ex));
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [63:0] held;

    tbl[0]  = '{32'hFFFF_FFF9, 32'd3,        1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "m7x3"};
    tbl[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "umax_sq"};
    tbl[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "m1_sq"};
    tbl[3]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "smin_sq"};
    tbl[4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, "smin_smax"};
    tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, "u2p31_sq"};
    tbl[6]  = '{32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, "u2p16_sq"};
    tbl[7]  = '{32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 64'h0000_0000_0000_0000, "zero"};
    tbl[8]  = '{32'hFFFF_FFFF, 32'd1,        1'b0, 64'h0000_0000_FFFF_FFFF, "umax_x1"};
    tbl[9]  = '{32'hFFFF_FFFF, 32'd1,        1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "m1_x1"};
    tbl[10] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001, "smax_sq"};

    rst = 1'b0;
    in_valid = 1'b0; op1 = '0; op2 = '0; tc = 1'b0; out_ready = 1'b1;
    s4_in_valid = 1'b0; s4_op1 = '0; s4_op2 = '0; s4_tc = 1'b0;
    s16_in_valid = 1'b0; s16_op1 = '0; s16_op2 = '0; s16_tc = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset P", P, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++)
      op32(tbl[i].a, tbl[i].b, tbl[i].t, tbl[i].p, tbl[i].nm);

    // Backpressure: result must hold for 10 cycles, in_valid pulses ignored.
    out_ready = 1'b0;
    @(negedge clk);
    op1 = 32'hFFFF_FFF9; op2 = 32'd3; tc = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 64'(lat), 64'd17);
    chk("bp P", P, 64'hFFFF_FFFF_FFFF_FFEB);
    held = 64'hFFFF_FFFF_FFFF_FFEB;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      op1 = 32'd100 + 32'(i); op2 = 32'd7; tc = 1'b0;
      @(posedge clk); #1;
      chk("bp out_valid held", 64'(out_valid), 64'd1);
      chk("bp P held", P, held);
      chk("bp in_ready low", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp handshake out_valid", 64'(out_valid), 64'd0);
    chk("bp handshake in_ready", 64'(in_ready), 64'd1);
    chk("bp P kept", P, held);
    @(posedge clk); #1;
    chk("bp no stray accept", 64'(busy), 64'd0);

    // Reset abort in the middle of RUN, between clock edges.
    @(negedge clk);
    op1 = 32'h1234_5678; op2 = 32'h0000_0ABC; tc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort in_ready", 64'(in_ready), 64'd1);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort P", P, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    op32(32'd12, 32'hFFFF_FFFB, 1'b1, 64'hFFFF_FFFF_FFFF_FFC4, "post_abort");

    // N=4 exhaustive, both modes.
    for (int t = 0; t < 2; t++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run4(4'(a), 4'(b), t[0]);

    // N=16 corners plus random operands, both modes.
    for (int t = 0; t < 2; t++) begin
      run16(16'h8000, 16'h8000, t[0]);
      run16(16'h8000, 16'h7FFF, t[0]);
      run16(16'hFFFF, 16'hFFFF, t[0]);
      for (int i = 0; i < 500; i++)
        run16(16'($urandom), 16'($urandom), t[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_r4_seq_mult.md
Name: booth_r4_seq_mult

Overview:
- Parametrised, iterative radix-4 Booth multiplier: width N, runtime signed/unsigned mode, valid/ready handshakes on input and output.
- Retires one Booth digit per clock into a shift-add accumulator.
- Sits in the arithmetic datapath, where it replaces free-running multipliers that have no start or done indication.
- Holds its result until the consumer accepts it.

Parameters:
- N, 32, operand width. Must be even and >= 4; other values are illegal, and elaboration must fail.
- K, (N+2)/2, number of Booth digits and RUN cycles. Derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands.
- op1  in  N  multiplicand.
- op2  in  N  multiplier.
- tc  in  1  1 = operands are two's complement, 0 = unsigned.
- out_valid  out  1  P holds a completed product.
- out_ready  in  1  consumer accepts P.
- P  out  2N  product.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: rst low asynchronously forces the following values; they hold while rst is low.
  - state=IDLE, in_ready=1, out_valid=0, busy=0, P=0.
  - Digit counter=0, accumulator=0, latched operands=0.
- Reset mid-operation: the computation in progress is discarded. There is no partial output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, go to RUN at that edge.
  - RUN: in_ready=0. Exactly K cycles.
  - DONE: out_valid=1. Hold until out_ready.
- Accept edge actions:
  - Latch M and Q: op1 and op2 extended to N+2 bits, sign-extended if tc=1, zero-extended if tc=0.
  - Clear the accumulator (width 2N+4), clear the digit counter, set the implicit q(-1)=0.
  - tc is sampled only at this edge.
- RUN, digit i (0..K-1): form triplet {Q[2i+1],Q[2i],q} where q=Q[2i-1], or 0 for i=0.
  - Encoding: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Partial product is sign-extended to 2N+4 bits, shifted left 2i, and added to the accumulator.
  - -M is two's complement at full partial-product width. The most negative input (for example 0x80000000 at N=32, tc=1) must be exact.
- End of RUN: after the K-th digit edge the state goes to DONE.
  - P = accumulator[2N-1:0], registered at that same edge.
  - out_valid goes high K cycles after the accept edge; at N=32 that is 17 cycles.
- Result width: the exact product fits in 2N bits in both modes. Upper accumulator bits are discarded.
- DONE: P and out_valid are stable until out_valid&&out_ready.
  - On that edge: go to IDLE, out_valid=0.
  - P keeps its last value; it is don't-care when out_valid=0, but the bench expects it held.
- in_ready is combinationally equal to (state==IDLE). No accept is possible in the handshake-completion cycle, so minimum issue interval is K+2 cycles.
- in_valid while busy: ignored. Operands are not buffered.
- out_ready while out_valid=0: ignored.
- op1/op2/tc changing during RUN: no effect.
- busy = (state != IDLE).

Test Plan:
- N=32, tc=1, op1=-7 (0xFFFFFFF9), op2=3, out_ready=1 -> out_valid exactly 17 cycles after accept; P=0xFFFFFFFFFFFFFFEB; back in IDLE one cycle later.
- N=32, tc=0, op1=op2=0xFFFFFFFF -> P=0xFFFFFFFE00000001. Same operands with tc=1 -> P=0x0000000000000001.
- N=32, tc=1, op1=op2=0x80000000 -> P=0x4000000000000000. Also op1=0x80000000, op2=0x7FFFFFFF -> P=0xC000000080000000.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - P and out_valid must be held.
  - in_ready must stay 0; in_valid pulses in that window are not accepted.
  - Raising out_ready completes the handshake, and in_ready=1 follows the next cycle.
- Reset abort: assert rst low at RUN digit 5 with no clock edge -> immediately out_valid=0, in_ready=1, P=0. After release, a new operation (op1=12, op2=-5, tc=1) gives P=0xFFFFFFFFFFFFFFC4.
- Parameter sweep N=4,8,16: exhaustive (N=4,8) or 10k random (N=16) operands in both modes, compared to a reference product. Latency must equal (N+2)/2 every time.
